// File: rtl/nnrv_pkg.sv
// Shared constants and helpers for the nn_riscv writeback/register-file slice.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package nnrv_pkg;

  localparam int XLEN_DEF   = 32;
  localparam int REG_ADDR_W = 5;
  localparam int REG_NUM    = 32;

  localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

  // Writeback sequencer states: clear the file first, then run forever.
  localparam logic [0:0] ST_INIT = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  // A writeback is architecturally visible only when enabled and not aimed at x0.
  function automatic logic is_arch_wr(input logic en, input logic [REG_ADDR_W-1:0] rd);
    return en && (rd != REG_ZERO);
  endfunction

endpackage

// File: rtl/nnrv_cnt.sv
// Free-running W-bit counter with enable; wraps from all-ones to zero silently.
// Latency: count visible one cycle after an enabled edge.
// Backpressure: none; the enable is the only qualifier.
module nnrv_cnt
  import nnrv_pkg::*;
#(
  parameter int W = 64
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_en,
  output logic [W-1:0] o_cnt
);

  localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1};

  // Increment on enable; natural modulo-2^W overflow provides the wrap.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_cnt <= '0;
    end else if (i_en) begin
      o_cnt <= o_cnt + ONE;
    end
  end

endmodule

// File: rtl/nnrv_wb_regfile.sv
// Writeback stage + 32x XLEN integer register file with write-through bypass, cycle/instret counters.
// Latency: reads combinational (zero cycles); writes commit at the next edge; trace one cycle after commit.
// Backpressure: o_busy stalls upstream for the 32-cycle post-reset clear; no stall once running.
// Optional feature macro: NNRV_WB_TRACE_EN (registered writeback trace port; tied to 0 when undefined).
module nnrv_wb_regfile
  import nnrv_pkg::*;
#(
  parameter int XLEN  = nnrv_pkg::XLEN_DEF,
  parameter int CNT_W = 64
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_mem_rd_en,
  input  logic [REG_ADDR_W-1:0] i_mem_rd,
  input  logic [XLEN-1:0]       i_mem_rd_reg,
  input  logic                  i_retire,
  input  logic [REG_ADDR_W-1:0] i_id_rs1,
  input  logic [REG_ADDR_W-1:0] i_id_rs2,
  output logic [XLEN-1:0]       o_id_rs1_reg,
  output logic [XLEN-1:0]       o_id_rs2_reg,
  output logic                  o_busy,
  output logic [CNT_W-1:0]      o_cycle,
  output logic [CNT_W-1:0]      o_instret,
  output logic                  o_trace_valid,
  output logic [REG_ADDR_W-1:0] o_trace_rd,
  output logic [XLEN-1:0]       o_trace_data
);

  logic [0:0]            state;
  logic [REG_ADDR_W-1:0] clr_idx;
  logic [XLEN-1:0]       regs [REG_NUM];

  logic                  run;
  logic                  commit;
  logic                  wr_en;
  logic [REG_ADDR_W-1:0] wr_idx;
  logic [XLEN-1:0]       wr_dat;

  assign run    = (state == ST_RUN);
  assign commit = run && is_arch_wr(i_mem_rd_en, i_mem_rd);
  assign o_busy = !run;

  // Clear sequencer: walk indices 0..31 once, then settle in ST_RUN for good.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state   <= ST_INIT;
      clr_idx <= '0;
    end else if (!run) begin
      clr_idx <= clr_idx + 5'd1;
      if (clr_idx == 5'd31) begin
        state <= ST_RUN;
      end
    end
  end

  // Single write port shared by the clear sequencer (zeros) and the pipeline writeback.
  always_comb begin
    wr_en  = commit;
    wr_idx = i_mem_rd;
    wr_dat = i_mem_rd_reg;
    if (!run) begin
      wr_en  = 1'b1;
      wr_idx = clr_idx;
      wr_dat = '0;
    end
  end

  // Storage is deliberately unreset; the clear sequencer provides the zero state.
  always_ff @(posedge i_clk) begin
    if (wr_en) begin
      regs[wr_idx] <= wr_dat;
    end
  end

  // Read port A: x0 and the clearing phase read zero; same-cycle writeback is forwarded.
  always_comb begin
    o_id_rs1_reg = '0;
    if (run && (i_id_rs1 != REG_ZERO)) begin
      if (commit && (i_mem_rd == i_id_rs1)) begin
        o_id_rs1_reg = i_mem_rd_reg;
      end else begin
        o_id_rs1_reg = regs[i_id_rs1];
      end
    end
  end

  // Read port B: same rules as port A, so both may forward one write together.
  always_comb begin
    o_id_rs2_reg = '0;
    if (run && (i_id_rs2 != REG_ZERO)) begin
      if (commit && (i_mem_rd == i_id_rs2)) begin
        o_id_rs2_reg = i_mem_rd_reg;
      end else begin
        o_id_rs2_reg = regs[i_id_rs2];
      end
    end
  end

  nnrv_cnt #(.W(CNT_W)) u_cycle (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .i_en  (run),
    .o_cnt (o_cycle)
  );

  nnrv_cnt #(.W(CNT_W)) u_instret (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .i_en  (run && i_retire),
    .o_cnt (o_instret)
  );

`ifdef NNRV_WB_TRACE_EN
  // Trace: one-cycle strobe echoing each committed write.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_trace_valid <= 1'b0;
      o_trace_rd    <= '0;
      o_trace_data  <= '0;
    end else begin
      o_trace_valid <= commit;
      o_trace_rd    <= commit ? i_mem_rd : '0;
      o_trace_data  <= commit ? i_mem_rd_reg : '0;
    end
  end
`else
  assign o_trace_valid = 1'b0;
  assign o_trace_rd    = '0;
  assign o_trace_data  = '0;
`endif

endmodule

// File: tb/tb_nnrv_wb_regfile.sv
// Directed bench for nnrv_wb_regfile: clear sequence, bypass, x0, counters, mid-run reset.
// Latency: n/a.
// Backpressure: n/a.
module tb_nnrv_wb_regfile;

  logic        i_clk;
  logic        i_rst;
  logic        i_mem_rd_en;
  logic [4:0]  i_mem_rd;
  logic [31:0] i_mem_rd_reg;
  logic        i_retire;
  logic [4:0]  i_id_rs1;
  logic [4:0]  i_id_rs2;
  logic [31:0] o_id_rs1_reg;
  logic [31:0] o_id_rs2_reg;
  logic        o_busy;
  logic [7:0]  o_cycle;
  logic [7:0]  o_instret;
  logic        o_trace_valid;
  logic [4:0]  o_trace_rd;
  logic [31:0] o_trace_data;

  int checks = 0;
  int errors = 0;

  nnrv_wb_regfile #(.XLEN(32), .CNT_W(8)) dut (
    .i_clk         (i_clk),
    .i_rst         (i_rst),
    .i_mem_rd_en   (i_mem_rd_en),
    .i_mem_rd      (i_mem_rd),
    .i_mem_rd_reg  (i_mem_rd_reg),
    .i_retire      (i_retire),
    .i_id_rs1      (i_id_rs1),
    .i_id_rs2      (i_id_rs2),
    .o_id_rs1_reg  (o_id_rs1_reg),
    .o_id_rs2_reg  (o_id_rs2_reg),
    .o_busy        (o_busy),
    .o_cycle       (o_cycle),
    .o_instret     (o_instret),
    .o_trace_valid (o_trace_valid),
    .o_trace_rd    (o_trace_rd),
    .o_trace_data  (o_trace_data)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance past one rising edge; inputs driven afterwards land well before the next edge.
  task automatic step();
    @(posedge i_clk);
    #2;
  endtask

  // Count cycles with o_busy high (bounded), noting any counter/read activity meanwhile.
  task automatic count_busy(output int n, output bit cyc_nz, output bit rd_nz);
    n = 0;
    cyc_nz = 1'b0;
    rd_nz = 1'b0;
    while (o_busy === 1'b1 && n < 100) begin
      #1;
      if (o_cycle !== 8'd0 || o_instret !== 8'd0) cyc_nz = 1'b1;
      if (o_id_rs1_reg !== 32'd0 || o_id_rs2_reg !== 32'd0) rd_nz = 1'b1;
      n++;
      step();
    end
  endtask

  int n_busy;
  bit cyc_nz;
  bit rd_nz;
  int guard;

  initial begin
    i_rst = 1'b1;
    i_mem_rd_en = 1'b0;
    i_mem_rd = 5'd0;
    i_mem_rd_reg = 32'd0;
    i_retire = 1'b0;
    i_id_rs1 = 5'd0;
    i_id_rs2 = 5'd0;

    step();
    step();
    chk("rst_busy", o_busy, 1);
    chk("rst_cycle", o_cycle, 0);
    chk("rst_instret", o_instret, 0);
    chk("rst_trace_valid", o_trace_valid, 0);
    chk("rst_trace_data", o_trace_data, 0);

    // Release reset with writes/retires/reads active: all must be ignored while clearing.
    i_rst = 1'b0;
    i_mem_rd_en = 1'b1;
    i_mem_rd = 5'd9;
    i_mem_rd_reg = 32'h0000_0055;
    i_retire = 1'b1;
    i_id_rs1 = 5'd9;
    i_id_rs2 = 5'd9;
    count_busy(n_busy, cyc_nz, rd_nz);
    chk("init_busy_cycles", n_busy, 32);
    chk("init_counters_held", cyc_nz, 0);
    chk("init_reads_zero", rd_nz, 0);

    // First ST_RUN cycle: counters still zero, ignored INIT write not present.
    i_mem_rd_en = 1'b0;
    i_retire = 1'b0;
    #1;
    chk("run0_cycle", o_cycle, 0);
    chk("run0_instret", o_instret, 0);
    chk("run0_x9_not_written", o_id_rs1_reg, 0);

    // Write on the very first ST_RUN cycle must commit.
    i_mem_rd_en = 1'b1;
    i_mem_rd = 5'd5;
    i_mem_rd_reg = 32'hDEAD_BEEF;
    step();
    i_mem_rd_en = 1'b0;
    i_id_rs1 = 5'd5;
    i_id_rs2 = 5'd0;
    #1;
    chk("run1_cycle", o_cycle, 1);
    chk("x5_read", o_id_rs1_reg, 32'hDEAD_BEEF);
    chk("x0_read", o_id_rs2_reg, 0);
`ifdef NNRV_WB_TRACE_EN
    chk("trace_x5_valid", o_trace_valid, 1);
    chk("trace_x5_rd", o_trace_rd, 5);
    chk("trace_x5_data", o_trace_data, 32'hDEAD_BEEF);
`else
    chk("trace_tied_valid", o_trace_valid, 0);
    chk("trace_tied_data", o_trace_data, 0);
`endif

    // Same-cycle write and read of x7 on both ports: bypass.
    i_mem_rd_en = 1'b1;
    i_mem_rd = 5'd7;
    i_mem_rd_reg = 32'h1234_5678;
    i_id_rs1 = 5'd7;
    i_id_rs2 = 5'd7;
    #1;
    chk("bypass_rs1", o_id_rs1_reg, 32'h1234_5678);
    chk("bypass_rs2", o_id_rs2_reg, 32'h1234_5678);
    step();
    i_mem_rd_en = 1'b0;
    i_id_rs2 = 5'd5;
    #1;
    chk("x7_after_commit", o_id_rs1_reg, 32'h1234_5678);
    chk("x5_still", o_id_rs2_reg, 32'hDEAD_BEEF);

    // Write to x0: never visible, never bypassed, never traced.
    i_mem_rd_en = 1'b1;
    i_mem_rd = 5'd0;
    i_mem_rd_reg = 32'hFFFF_FFFF;
    i_id_rs1 = 5'd0;
    #1;
    chk("x0_no_bypass", o_id_rs1_reg, 0);
    step();
    i_mem_rd_en = 1'b0;
    #1;
    chk("x0_after_write", o_id_rs1_reg, 0);
    chk("x0_no_trace", o_trace_valid, 0);

    // x3 = 0xA, then four retire pulses.
    i_mem_rd_en = 1'b1;
    i_mem_rd = 5'd3;
    i_mem_rd_reg = 32'h0000_000A;
    step();
    i_mem_rd_en = 1'b0;
    i_id_rs1 = 5'd3;
    #1;
    chk("x3_read", o_id_rs1_reg, 32'h0000_000A);
    for (int k = 0; k < 4; k++) begin
      i_retire = 1'b1;
      step();
      i_retire = 1'b0;
      step();
    end
    #1;
    chk("instret_4", o_instret, 4);

    // Cycle counter wrap with the 8-bit build.
    guard = 0;
    while (o_cycle !== 8'hFF && guard < 400) begin
      step();
      guard++;
    end
    chk("cycle_reach_ff", o_cycle, 8'hFF);
    step();
    chk("cycle_wrap", o_cycle, 0);
    chk("instret_hold", o_instret, 4);

    // Mid-run reset: back to clear, counters zeroed, x3 gone.
    i_rst = 1'b1;
    #1;
    chk("rst2_busy", o_busy, 1);
    chk("rst2_cycle", o_cycle, 0);
    chk("rst2_instret", o_instret, 0);
    chk("rst2_trace", o_trace_valid, 0);
    step();
    step();
    i_rst = 1'b0;
    i_id_rs1 = 5'd3;
    i_id_rs2 = 5'd7;
    count_busy(n_busy, cyc_nz, rd_nz);
    chk("rst2_busy_cycles", n_busy, 32);
    chk("rst2_counters_held", cyc_nz, 0);
    #1;
    chk("rst2_x3_cleared", o_id_rs1_reg, 0);
    chk("rst2_x7_cleared", o_id_rs2_reg, 0);
    chk("rst2_instret_run", o_instret, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/nnrv_wb_regfile.md
Name: nnrv_wb_regfile

Overview:
- Writeback stage and integer register file of the nn_riscv pipeline, directly downstream of the memory stage.
- Consumes the memory stage's registered writeback triple (enable, destination, data) and commits it to the 32-entry register file.
- Serves two combinational read ports to the decode stage, with write-through bypass.
- Holds the cycle and instret counters.
- After reset, a clear sequencer zeroes every register before the pipeline may run.

Parameters:
- XLEN, 32, data width of registers and ports.
- CNT_W, 64, width of the cycle and instret counters.

Ports:
- i_clk  in  1  clock
- i_rst  in  1  reset
- i_mem_rd_en  in  1  writeback enable from the memory stage
- i_mem_rd  in  5  destination register index
- i_mem_rd_reg  in  XLEN  writeback data
- i_retire  in  1  one instruction retires this cycle
- i_id_rs1  in  5  decode read index A
- i_id_rs2  in  5  decode read index B
- o_id_rs1_reg  out  XLEN  read data A
- o_id_rs2_reg  out  XLEN  read data B
- o_busy  out  1  clear sequence in progress; upstream stalls while high
- o_cycle  out  CNT_W  cycle counter
- o_instret  out  CNT_W  retired-instruction counter
- o_trace_valid  out  1  trace strobe (see Optional Feature)
- o_trace_rd  out  5  trace destination index
- o_trace_data  out  XLEN  trace data

Behaviour:
- Reset: i_rst asynchronous, active-high; clock i_clk.
  - On reset: state=ST_INIT, clr_idx=0, o_busy=1, o_cycle=0, o_instret=0, trace outputs 0.
- ST_INIT:
  - Each cycle writes 0 to regs[clr_idx], then clr_idx+1.
  - The cycle that writes index 31 transitions to ST_RUN.
  - o_busy is high for exactly 32 cycles after reset release.
  - Read ports return 0.
  - i_mem_rd_en and i_retire are ignored.
  - Counters hold 0.
- ST_RUN:
  - Write: at posedge, regs[i_mem_rd] <= i_mem_rd_reg when i_mem_rd_en=1 and i_mem_rd!=0.
  - x0 is never written.
- Reads: combinational, zero latency.
  - Index 0 reads 0.
  - Bypass: if i_mem_rd_en=1, i_mem_rd!=0 and i_mem_rd==rsN, then o_id_rsN_reg = i_mem_rd_reg. Otherwise o_id_rsN_reg = regs[rsN].
  - Both ports may bypass the same write simultaneously.
- Counters (ST_RUN only):
  - o_cycle += 1 every clock.
  - o_instret += 1 when i_retire=1.
  - Both wrap from all-ones to 0 with no flag.
- Simultaneous events:
  - Write and read of the same index in one cycle returns the new data via bypass.
  - A write on the first ST_RUN cycle is committed.
- Reset mid-operation (any state): returns to ST_INIT, restarts the clear from index 0, zeroes the counters.
- State ST_RUN is absorbing; ST_INIT is left only via the 32-cycle clear.

Optional Feature:
- Macro NNRV_WB_TRACE_EN.
- Defined:
  - One cycle after each committed write (ST_RUN, en=1, rd!=0), o_trace_valid=1 for one cycle.
  - o_trace_rd and o_trace_data carry that write's index and data.
  - Writes to x0 and writes during ST_INIT produce no trace.
- Undefined: o_trace_valid, o_trace_rd and o_trace_data are tied to 0; no trace registers exist.

Decomposition:
- Shared package nnrv_pkg:
  - XLEN default
  - REG_ADDR_W=5
  - REG_NUM=32
  - REG_ZERO=5'd0
  - state encodings ST_INIT=1'b0, ST_RUN=1'b1
- One sub-module, nnrv_cnt: a CNT_W-bit counter with asynchronous reset, enable and wrap. It is instantiated twice, for cycle and instret.

Test Plan:
- Reset release, then sample o_busy each cycle -> o_busy=1 for exactly 32 cycles, then 0; o_cycle=0 throughout ST_INIT and 1 on the first cycle after the first ST_RUN edge.
- ST_RUN: write x5=32'hDEADBEEF, next cycle read rs1=5 and rs2=0 -> 32'hDEADBEEF and 0.
- Same cycle: en=1, rd=7, data=32'h12345678, rs1=rs2=7 -> both ports 32'h12345678 combinationally; a later read of x7 still returns 32'h12345678.
- Write rd=0, data=32'hFFFFFFFF, then read x0 -> 0; with NNRV_WB_TRACE_EN, o_trace_valid stays 0.
- Write x3=32'hA during run, pulse i_retire 4 times, then assert i_rst mid-stream -> after release, x3 reads 0 once ST_RUN is reached, o_instret=0, o_busy high again for 32 cycles.
- Force o_cycle to all-ones via a long run or a bench preload with CNT_W=8 -> the next clock reads 0.
